// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU add/subtract datapath.
//   ADD / SUB  : opcode encodings for the op_sub input
//   seg_width  : carry-chain segment width for a given word width and depth
//   flags_t    : status flag bundle registered alongside the result
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;

   // Bits handled by one pipeline stage; width must divide evenly by stages.
   function automatic int seg_width(input int width, input int stages);
      return width / stages;
   endfunction

   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
   } flags_t;

endpackage

// File: rtl/cla_segment.sv
// -----------------------------------------------------------------------------
// cla_segment
// Combinational carry-lookahead adder for one pipeline segment. Bits are
// split into GROUP-wide lookahead groups; inside a group every carry comes
// from the group-prefix generate/propagate terms, and group carries chain
// from one group to the next.
// Ports:
//   a_seg, b_seg [SEG-1:0] : operand bits (b already conditioned for subtract)
//   cin                    : carry into bit 0 of the segment
//   sum_seg [SEG-1:0]      : segment sum
//   cout                   : carry out of the segment MSB
//   c_msb                  : carry into the segment MSB (signed overflow term)
// -----------------------------------------------------------------------------
module cla_segment #(
   parameter int SEG   = 8,
   parameter int GROUP = 4
) (
   input  logic [SEG-1:0] a_seg,
   input  logic [SEG-1:0] b_seg,
   input  logic           cin,
   output logic [SEG-1:0] sum_seg,
   output logic           cout,
   output logic           c_msb
);

   localparam int NGRP = SEG / GROUP;

   logic [SEG-1:0] gen;
   logic [SEG-1:0] prop;
   logic [SEG-1:0] carry;

   assign gen  = a_seg & b_seg;
   assign prop = a_seg ^ b_seg;

   always_comb begin : p_lookahead
      logic grp_c;   // carry into the current group
      logic pre_g;   // prefix generate of the bits below idx inside the group
      logic pre_p;   // prefix propagate of the same bits
      // NOTE: every combinational output gets a value before any loop or
      // branch, so no path can leave it holding state (no latch).
      carry = '0;
      cout  = 1'b0;
      grp_c = cin;
      for (int j = 0; j < NGRP; j++) begin
         pre_g = 1'b0;
         pre_p = 1'b1;
         for (int i = 0; i < GROUP; i++) begin
            carry[j*GROUP + i] = pre_g | (pre_p & grp_c);
            pre_g = gen[j*GROUP + i] | (prop[j*GROUP + i] & pre_g);
            pre_p = pre_p & prop[j*GROUP + i];
         end
         grp_c = pre_g | (pre_p & grp_c);
      end
      cout = grp_c;
   end

   assign sum_seg = prop ^ carry;
   assign c_msb   = carry[SEG-1];

endmodule

// File: rtl/pipelined_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_addsub
// Pipelined add/subtract with carry-in and signed/unsigned status flags.
// Operands are captured in an input register, then the carry chain is
// resolved one SEG-bit segment per stage over STAGES stages; the last stage
// forms the flags and loads the output register. Latency is STAGES cycles
// from the accepting edge. Bubbles travel with the pipeline; a stall at the
// output freezes every stage.
//
// Optional build macro: ADDSUB_SATURATE_EN adds the 'sat' input; a beat
// with sat = 1 whose signed result overflows is clamped to the signed limit.
//
// Ports:
//   clk, clr_n          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready never depends on in_valid)
//   a, b [WIDTH-1:0]    : operands
//   op_sub              : 0 = a + b + cin, 1 = a - b - cin (cin is borrow)
//   cin                 : carry-in / borrow-in
//   sat                 : clamp on signed overflow (ADDSUB_SATURATE_EN only)
//   out_valid/out_ready : result handshake
//   sum [WIDTH-1:0]     : result
//   cout                : carry out (add) / not-borrow (sub)
//   ovf                 : signed overflow
//   zero                : sum == 0
// WIDTH must be a multiple of STAGES, and GROUP must divide WIDTH/STAGES.
// -----------------------------------------------------------------------------
module pipelined_addsub
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4,
   parameter int GROUP  = 4
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op_sub,
   input  logic             cin,
`ifdef ADDSUB_SATURATE_EN
   input  logic             sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int SEG = seg_width(WIDTH, STAGES);
   localparam int TOP = (STAGES - 1) * SEG;   // lowest bit of the last segment

   // Stage k registers feed segment k: operands (the skew), the carry into
   // segment k, and the sum bits already resolved below k*SEG.
   logic [STAGES-1:0]            vld_q, vld_d;
   logic [STAGES-1:0][WIDTH-1:0] opa_q, opa_d;
   logic [STAGES-1:0][WIDTH-1:0] opb_q, opb_d;
   logic [STAGES-1:0][WIDTH-1:0] part_q, part_d;
   logic [STAGES-1:0]            cy_q, cy_d;
`ifdef ADDSUB_SATURATE_EN
   logic [STAGES-1:0]            sat_q, sat_d;
`endif

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   flags_t           flags_q, flags_d;

   logic [STAGES-1:0][SEG-1:0] seg_sum;
   logic [STAGES-1:0]          seg_cout;
   logic [STAGES-1:0]          seg_cmsb;

   logic             advance;
   logic [WIDTH-1:0] b_eff;
   logic             c0;
   logic [WIDTH-1:0] res;
   logic             res_cout;
   logic             res_ovf;

   // Subtract is a + ~b + ~borrow.
   assign b_eff = (op_sub == SUB) ? ~b : b;
   assign c0    = (op_sub == SUB) ? ~cin : cin;

   // The whole pipeline moves together unless a held result is refused.
   assign advance  = ~out_valid_q | out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_seg
      cla_segment #(
         .SEG   (SEG),
         .GROUP (GROUP)
      ) u_seg (
         .a_seg   (opa_q[k][k*SEG +: SEG]),
         .b_seg   (opb_q[k][k*SEG +: SEG]),
         .cin     (cy_q[k]),
         .sum_seg (seg_sum[k]),
         .cout    (seg_cout[k]),
         .c_msb   (seg_cmsb[k])
      );
   end

`ifdef ADDSUB_SATURATE_EN
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   // Last stage: assemble the full word and its flags.
   always_comb begin
      res              = part_q[STAGES-1];
      res[TOP +: SEG]  = seg_sum[STAGES-1];
      res_cout         = seg_cout[STAGES-1];
      res_ovf          = seg_cmsb[STAGES-1] ^ res_cout;
`ifdef ADDSUB_SATURATE_EN
      // Overflow with no carry out means two positives wrapped negative.
      if (sat_q[STAGES-1] && res_ovf) begin
         res = res_cout ? SMIN : SMAX;
      end
`endif
   end

   always_comb begin
      vld_d       = vld_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      part_d      = part_q;
      cy_d        = cy_q;
`ifdef ADDSUB_SATURATE_EN
      sat_d       = sat_q;
`endif
      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      flags_d     = flags_q;

      if (advance) begin
         // Payloads load only behind a valid slot, so a bubble leaves the
         // previous contents (and the output fields) untouched.
         vld_d[0] = in_valid;
         if (in_valid) begin
            opa_d[0]  = a;
            opb_d[0]  = b_eff;
            cy_d[0]   = c0;
            part_d[0] = '0;
`ifdef ADDSUB_SATURATE_EN
            sat_d[0]  = sat;
`endif
         end

         for (int k = 1; k < STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
            if (vld_q[k-1]) begin
               opa_d[k]                   = opa_q[k-1];
               opb_d[k]                   = opb_q[k-1];
               cy_d[k]                    = seg_cout[k-1];
               part_d[k]                  = part_q[k-1];
               part_d[k][(k-1)*SEG +: SEG] = seg_sum[k-1];
`ifdef ADDSUB_SATURATE_EN
               sat_d[k]                   = sat_q[k-1];
`endif
            end
         end

         out_valid_d = vld_q[STAGES-1];
         if (vld_q[STAGES-1]) begin
            sum_d        = res;
            flags_d.cout = res_cout;
            flags_d.ovf  = res_ovf;
            flags_d.zero = ~|res;
         end
      end
   end

   // Data registers are cleared too: the result fields must read zero
   // after reset, and a reset must wipe every in-flight beat.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge value of the others.
         vld_q       <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         part_q      <= '0;
         cy_q        <= '0;
`ifdef ADDSUB_SATURATE_EN
         sat_q       <= '0;
`endif
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         flags_q     <= '0;
      end else begin
         vld_q       <= vld_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         part_q      <= part_d;
         cy_q        <= cy_d;
`ifdef ADDSUB_SATURATE_EN
         sat_q       <= sat_d;
`endif
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         flags_q     <= flags_d;
      end
   end

   // The last stage's operand bits below its segment and the MSB carries of
   // the lower segments have no reader; collecting them keeps that explicit.
   logic unused_bits;
   assign unused_bits = ^{opa_q[STAGES-1], opb_q[STAGES-1], seg_cmsb};

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = flags_q.cout;
   assign ovf       = flags_q.ovf;
   assign zero      = flags_q.zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_addsub
// Directed bench for pipelined_addsub at WIDTH=32, STAGES=4, GROUP=4.
// Every expected value below is worked out by hand from the operands.
// -----------------------------------------------------------------------------
module tb_pipelined_addsub;
   import alu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         clr_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         op_sub;
   logic         cin;
   logic         sat_drv;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         zero;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipelined_addsub #(
      .WIDTH  (W),
      .STAGES (4),
      .GROUP  (4)
   ) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op_sub    (op_sub),
      .cin       (cin),
`ifdef ADDSUB_SATURATE_EN
      .sat       (sat_drv),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sub, input logic ci, input logic s);
      a       = av;
      b       = bv;
      op_sub  = sub;
      cin     = ci;
      sat_drv = s;
   endtask

   // One beat through an empty pipeline; checks latency and all result fields.
   task automatic run_single(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic sub, input logic ci, input logic s,
                             input logic [W-1:0] exp_sum, input logic exp_cout,
                             input logic exp_ovf, input logic exp_zero);
      int lat;
      out_ready = 1'b1;
      drive(av, bv, sub, ci, s);
      in_valid = 1'b1;
      check({tag, "_in_ready"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, lat, 4);
      check({tag, "_sum"},  sum,  exp_sum);
      check({tag, "_cout"}, cout, exp_cout);
      check({tag, "_ovf"},  ovf,  exp_ovf);
      check({tag, "_zero"}, zero, exp_zero);
      tick();
      check({tag, "_drained"}, out_valid, 0);
   endtask

   logic [W-1:0] sa [8];
   logic [W-1:0] sb [8];
   logic         ssub [8];
   logic [W-1:0] se [8];

   initial begin
      int sent;
      int rcvd;
      int cyc;
      bit saw_block;

      clr_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drive('0, '0, ADD, 1'b0, 1'b0);

      // ---------------- reset and idle ----------------
      repeat (3) tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_sum",  sum,  0);
      check("rst_cout", cout, 0);
      check("rst_ovf",  ovf,  0);
      check("rst_zero", zero, 0);
      clr_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("idle%0d_in_ready", i), in_ready, 1);
         check($sformatf("idle%0d_out_valid", i), out_valid, 0);
         check($sformatf("idle%0d_sum", i), sum, 0);
         tick();
      end

      // ---------------- stream with output stall ----------------
      sa[0] = 32'h0000_0001; sb[0] = 32'h0000_0002; ssub[0] = ADD; se[0] = 32'h0000_0003;
      sa[1] = 32'h0000_000A; sb[1] = 32'h0000_0003; ssub[1] = SUB; se[1] = 32'h0000_0007;
      sa[2] = 32'h0000_0100; sb[2] = 32'h0000_0100; ssub[2] = ADD; se[2] = 32'h0000_0200;
      sa[3] = 32'hFFFF_FFFF; sb[3] = 32'hFFFF_FFFF; ssub[3] = ADD; se[3] = 32'hFFFF_FFFE;
      sa[4] = 32'h0000_0000; sb[4] = 32'h0000_0001; ssub[4] = SUB; se[4] = 32'hFFFF_FFFF;
      sa[5] = 32'h0000_FFFF; sb[5] = 32'h0000_0001; ssub[5] = ADD; se[5] = 32'h0001_0000;
      sa[6] = 32'h00FF_00FF; sb[6] = 32'hFF00_FF00; ssub[6] = ADD; se[6] = 32'hFFFF_FFFF;
      sa[7] = 32'h0000_0064; sb[7] = 32'h0000_0064; ssub[7] = SUB; se[7] = 32'h0000_0000;

      sent      = 0;
      rcvd      = 0;
      cyc       = 0;
      saw_block = 1'b0;
      while (rcvd < 8 && cyc < 100) begin
         out_ready = !(cyc >= 2 && cyc < 8);
         if (sent < 8) begin
            drive(sa[sent], sb[sent], ssub[sent], 1'b0, 1'b0);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (in_valid && !in_ready) saw_block = 1'b1;
         // Also checked on stalled cycles: the held result must not move.
         if (out_valid) begin
            check($sformatf("stream%0d_sum", rcvd), sum, se[rcvd]);
            if (out_ready) rcvd++;
         end
         if (in_valid && in_ready) sent++;
         tick();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("stream_received", rcvd, 8);
      check("stream_sent", sent, 8);
      check("stream_in_ready_dropped", saw_block, 1);
      for (int i = 0; i < 6; i++) begin
         check("stream_no_extra_beat", out_valid, 0);
         tick();
      end

      // ---------------- directed single beats ----------------
      run_single("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, ADD, 1'b0, 1'b0,
                 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      run_single("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, ADD, 1'b0, 1'b0,
                 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      run_single("sub_borrow", 32'h0000_0005, 32'h0000_0007, SUB, 1'b0, 1'b0,
                 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      run_single("sub_pos",   32'h0000_0007, 32'h0000_0005, SUB, 1'b0, 1'b0,
                 32'h0000_0002, 1'b1, 1'b0, 1'b0);
      run_single("add_cin",   32'h1234_5678, 32'h1111_1111, ADD, 1'b1, 1'b0,
                 32'h2345_678A, 1'b0, 1'b0, 1'b0);
      run_single("sub_bin_ovf", 32'h8000_0000, 32'h0000_0001, SUB, 1'b1, 1'b0,
                 32'h7FFF_FFFE, 1'b1, 1'b1, 1'b0);
`ifdef ADDSUB_SATURATE_EN
      run_single("sat_pos",   32'h7FFF_FFFF, 32'h0000_0001, ADD, 1'b0, 1'b1,
                 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
      run_single("sat_neg",   32'h8000_0000, 32'h0000_0001, SUB, 1'b1, 1'b1,
                 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`endif

      // ---------------- reset mid-flight ----------------
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(W'(i + 1), 32'h0000_0001, ADD, 1'b0, 1'b0);
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      clr_n    = 1'b0;
      tick();
      check("midrst_out_valid", out_valid, 0);
      check("midrst_sum",  sum,  0);
      check("midrst_cout", cout, 0);
      check("midrst_ovf",  ovf,  0);
      check("midrst_zero", zero, 0);
      clr_n = 1'b1;
      check("midrst_in_ready", in_ready, 1);
      for (int i = 0; i < 6; i++) begin
         check("midrst_flushed", out_valid, 0);
         tick();
      end
      run_single("post_rst", 32'h0000_0001, 32'h0000_0001, ADD, 1'b0, 1'b0,
                 32'h0000_0002, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised successor to the 32-bit combinational carry-lookahead adder.
- Generalised width; add/subtract with carry-in; signed/unsigned status flags.
- Carry chain split across STAGES register stages, with a valid/ready handshake on both sides.
- Sits in the ALU datapath, feeding the result and flag registers; used where the single-cycle 32-bit carry chain cannot meet timing.

Parameters:
- WIDTH, 32: operand/result width in bits; must be divisible by STAGES.
- STAGES, 4: pipeline depth; the carry chain is split into STAGES segments of SEG = WIDTH/STAGES bits.
- GROUP, 4: lookahead group size inside a segment; must divide SEG.

Ports:
- clk  in  1  rising-edge clock
- clr_n  in  1  synchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op_sub  in  1  0 = A+B+cin; 1 = A-B-borrow (A + ~B + ~cin)
- cin  in  1  carry-in (add) / active-high borrow-in (sub)
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts the result
- sum  out  WIDTH  result
- cout  out  1  carry-out (add); NOT borrow (sub): 1 = no borrow
- ovf  out  1  signed overflow
- zero  out  1  sum == 0

Behaviour:
- Reset:
  - Sampled on the rising clk edge when clr_n = 0. There is one clock; reset is synchronous and active-low.
  - All stage valid bits clear. out_valid = 0; sum, cout, ovf and zero = 0.
  - in_ready = 1 in the first cycle after reset releases.
  - Reset asserted mid-operation discards every in-flight beat. No partial result is ever presented.
- Operand conditioning at acceptance:
  - b_eff = op_sub ? ~b : b.
  - c0 = op_sub ? ~cin : cin.
- Pipeline:
  - Stage k (0..STAGES-1) computes bits [k*SEG +: SEG] using GROUP-wide generate/propagate lookahead, with carry-in from the stage k-1 register (c0 for k=0).
  - Each stage registers its computed sum bits, its segment carry-out, and the not-yet-consumed upper operand bits (skew).
  - Lower sum bits are delayed so the whole word aligns at the output register.
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+STAGES, assuming no stall.
- Handshake:
  - advance = ~out_valid | out_ready.
  - in_ready = advance (combinational from out_valid/out_ready only; never from in_valid).
  - A beat is accepted when in_valid & in_ready.
  - When advance = 0, every stage holds its contents, and the output fields stay stable while out_valid = 1.
  - Bubbles are carried, not collapsed: an invalid slot still occupies a stage.
- Throughput: 1 beat/cycle when out_ready stays high.
- Flags (computed in the last stage, registered with sum):
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = ~|sum.
- Boundaries:
  - Simultaneous accept at input and drain at output in the same cycle is legal: no bubble is inserted.
  - Full pipeline with out_ready = 0 gives in_ready = 0.
  - Operand wrap-around is modulo 2^WIDTH; cout reports the carry that leaves the word.
- STAGES = 1 degenerates to a single registered CLA with latency 1.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined:
  - Adds input port sat (1 bit), carried through the pipeline with its beat.
  - When sat = 1 and the signed result overflows, sum is clamped: 2^(WIDTH-1)-1 for positive overflow, -2^(WIDTH-1) for negative overflow.
  - ovf still reports 1; zero is computed on the clamped value.
- Undefined: no sat port; sum always wraps. Zero extra logic.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants ADD = 1'b0, SUB = 1'b1.
  - A function returning SEG = WIDTH/STAGES.
  - Flag-bundle typedef {cout, ovf, zero}.
- Sub-module cla_segment, parametrised on SEG and GROUP:
  - Inputs: a_seg, b_seg, cin.
  - Outputs: sum_seg, cout, carry-into-MSB (used only by the top segment for ovf).
  - Purely combinational; instantiated STAGES times.
- Top level holds the stage registers, skew/alignment registers and handshake.

Test Plan (WIDTH=32, STAGES=4):
- Reset then idle -> out_valid = 0, sum = 0, in_ready = 1 every cycle.
- Add 0xFFFFFFFF + 0x00000001, cin = 0 -> after exactly 4 cycles: sum = 0x00000000, cout = 1, zero = 1, ovf = 0 (carry ripples through all 4 stages).
- Add 0x7FFFFFFF + 0x00000001 -> sum = 0x80000000, ovf = 1, cout = 0. With ADDSUB_SATURATE_EN and sat = 1 -> sum = 0x7FFFFFFF, ovf = 1.
- Sub 5 - 7, cin = 0 -> sum = 0xFFFFFFFE, cout = 0 (borrow), ovf = 0. Sub 7 - 5 -> sum = 0x00000002, cout = 1.
- Stream 8 random beats back-to-back with out_ready = 0 from cycle 2 for 6 cycles -> in_ready drops once the pipeline fills; no beat lost or duplicated; results match the reference model in order; output stable while stalled.
- Accept 3 beats, pull clr_n low for 1 cycle mid-flight -> next edge out_valid = 0, flags = 0; the following fresh beat 1+1 returns sum = 2 with latency 4.
